// File: rtl/f_adder_arb.sv
// Round-robin arbiter that shares one f_adder among N requesters and returns id-tagged results.
// Optional statistics counters are built when F_ADDER_ARB_STATS_EN is defined.
module f_adder_arb #(
    parameter int N       = 4,
    parameter int ADD_LAT = 1,
    parameter int ID_W    = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req_valid,
    input  logic [N*32-1:0]   req_in0,
    input  logic [N*32-1:0]   req_in1,
    input  logic [N-1:0]      req_op,
    output logic [N-1:0]      req_ready,
    output logic [31:0]       add_in0,
    output logic [31:0]       add_in1,
    output logic              add_op,
    input  logic [31:0]       add_out,
    output logic              rsp_valid,
    output logic [ID_W-1:0]   rsp_id,
    output logic [31:0]       rsp_data
`ifdef F_ADDER_ARB_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [15:0]       stat_ops,
    output logic [15:0]       stat_busy
`endif
);

    localparam logic [ID_W:0] N_W = (ID_W+1)'(N);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] ptr, ptr_nxt, gnt_idx, id_p0;
    logic [3:0]      cnt;
    logic [2*N-1:0]  dbl;
    logic [N-1:0]    rot;
    logic [ID_W:0]   sum, inc;
    logic            found, hs, done;
    logic [31:0]     sel_in0, sel_in1;
    logic            sel_op;

    // Rotate the request vector so bit 0 is the current highest-priority requester.
    assign dbl  = {req_valid, req_valid} >> ptr;
    assign rot  = dbl[N-1:0];
    assign hs   = (state == IDLE) && found;
    assign done = (state == BUSY) && (cnt == 4'd0);

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + (ID_W+1)'(k);
                if (sum >= N_W) sum = sum - N_W;
                gnt_idx = sum[ID_W-1:0];
            end
        end
        inc     = {1'b0, gnt_idx} + (ID_W+1)'(1);
        ptr_nxt = (inc == N_W) ? '0 : inc[ID_W-1:0];
    end

    always_comb begin
        req_ready = '0;
        sel_in0   = '0;
        sel_in1   = '0;
        sel_op    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                sel_in0 = req_in0[32*i +: 32];
                sel_in1 = req_in1[32*i +: 32];
                sel_op  = req_op[i];
            end
        end
        if (hs) req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        if (state == IDLE) begin
            if (hs) state_nxt = BUSY;
        end else if (cnt == 4'd0) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Issue stage: operands held on the adder inputs until the next grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            cnt       <= 4'd0;
            id_p0     <= '0;
            add_in0   <= '0;
            add_in1   <= '0;
            add_op    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= done;
            if (hs) begin
                add_in0 <= sel_in0;
                add_in1 <= sel_in1;
                add_op  <= sel_op;
                id_p0   <= gnt_idx;
                ptr     <= ptr_nxt;
                cnt     <= 4'(ADD_LAT);
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            // Response stage: adder result captured once the latency has elapsed.
            if (done) begin
                rsp_data <= add_out;
                rsp_id   <= id_p0;
            end
        end
    end

`ifdef F_ADDER_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ops  <= 16'd0;
            stat_busy <= 16'd0;
        end else if (stat_clr) begin
            stat_ops  <= 16'd0;
            stat_busy <= 16'd0;
        end else begin
            if (rsp_valid && stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
            if (state == BUSY && stat_busy != 16'hFFFF) stat_busy <= stat_busy + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_f_adder_arb.sv
// Directed bench for f_adder_arb with a behavioural single-precision adder of latency 1.
module tb_f_adder_arb;

    localparam int N       = 4;
    localparam int ADD_LAT = 1;
    localparam int ID_W    = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_op, req_ready;
    logic [N*32-1:0] req_in0, req_in1;
    logic [31:0]     add_in0, add_in1, add_out, rsp_data;
    logic            add_op, rsp_valid;
    logic [ID_W-1:0] rsp_id;
`ifdef F_ADDER_ARB_STATS_EN
    logic            stat_clr;
    logic [15:0]     stat_ops, stat_busy;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    f_adder_arb #(.N(N), .ADD_LAT(ADD_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_in0(req_in0), .req_in1(req_in1), .req_op(req_op),
        .req_ready(req_ready),
        .add_in0(add_in0), .add_in1(add_in1), .add_op(add_op), .add_out(add_out),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data)
`ifdef F_ADDER_ARB_STATS_EN
        , .stat_clr(stat_clr), .stat_ops(stat_ops), .stat_busy(stat_busy)
`endif
    );

    // Behavioural f_adder for normal numbers and zero, converted through double precision.
    function automatic real sp2r(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:23] == 8'd0) return 0.0;
        d = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 32'h0;
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    always @(posedge clk)
        add_out <= r2sp(add_op ? sp2r(add_in0) - sp2r(add_in1) : sp2r(add_in0) + sp2r(add_in1));

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[4];
    int   order[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ready"},     32'(req_ready), 32'h0);
        check({tag, "_add_in0"},   add_in0,        32'h0);
        check({tag, "_add_in1"},   add_in1,        32'h0);
        check({tag, "_add_op"},    32'(add_op),    32'h0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, "_rsp_id"},    32'(rsp_id),    32'h0);
        check({tag, "_rsp_data"},  rsp_data,       32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        tick();
        check_zero_outputs("reset");
        rst = 1'b0;
        tick();
    endtask

    // One isolated operation from requester v.id; starts and ends in an idle cycle.
    task automatic single_op(input vec_t v);
        req_valid = 4'b0001 << v.id;
        #1;
        check("single_grant", 32'(req_ready), 32'(1) << v.id);
        tick();
        req_valid = '0;
        check("single_add_in0", add_in0, v.a);
        check("single_add_in1", add_in1, v.b);
        check("single_add_op", 32'(add_op), 32'(v.op));
        check("single_busy_ready", 32'(req_ready), 32'h0);
        check("single_rsp_early", 32'(rsp_valid), 32'h0);
        tick();
        check("single_add_op_busy", 32'(add_op), 32'(v.op));
        check("single_rsp_early2", 32'(rsp_valid), 32'h0);
        tick();
        check("single_rsp_valid", 32'(rsp_valid), 32'h1);
        check("single_rsp_id", 32'(rsp_id), 32'(v.id));
        check("single_rsp_data", rsp_data, v.exp);
        tick();
        check("single_rsp_pulse", 32'(rsp_valid), 32'h0);
        check("single_rsp_hold", rsp_data, v.exp);
    endtask

    // All requesters valid from pointer 0: grants must rotate 0,1,2,3,0 every 3 cycles.
    task automatic stream(input int n);
        int id;
        req_valid = '1;
        #1;
        for (int g = 0; g < n; g++) begin
            id = g % N;
            check("stream_grant", 32'(req_ready), 32'(1) << id);
            tick();
            if (g == n - 1) req_valid = '0;
            check("stream_ready_busy", 32'(req_ready), 32'h0);
            check("stream_add_in0", add_in0, vecs[id].a);
            check("stream_rsp_early", 32'(rsp_valid), 32'h0);
            tick();
            check("stream_ready_busy2", 32'(req_ready), 32'h0);
            tick();
            check("stream_rsp_valid", 32'(rsp_valid), 32'h1);
            check("stream_rsp_id", 32'(rsp_id), 32'(id));
            check("stream_rsp_data", rsp_data, vecs[id].exp);
        end
    endtask

    initial begin
        vecs[0] = '{0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000};
        vecs[1] = '{1, 32'h41200000, 32'h40A00000, 1'b0, 32'h41700000};
        vecs[2] = '{2, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000};
        vecs[3] = '{3, 32'h41200000, 32'h40A00000, 1'b1, 32'h40A00000};
        order   = '{0, 2, 1, 3};

        rst       = 1'b1;
        req_valid = '0;
        req_in0   = '0;
        req_in1   = '0;
        req_op    = '0;
`ifdef F_ADDER_ARB_STATS_EN
        stat_clr  = 1'b0;
`endif
        for (int i = 0; i < N; i++) begin
            req_in0[32*i +: 32] = vecs[i].a;
            req_in1[32*i +: 32] = vecs[i].b;
            req_op[i]           = vecs[i].op;
        end

        do_reset();

        // Isolated operations, including add and subtract.
        for (int i = 0; i < 4; i++) single_op(vecs[order[i]]);

        // Pointer at 2 with requesters 1 and 3 pending: 3 first, then wrap to 1.
        single_op(vecs[1]);
        req_valid = 4'b1010;
        #1;
        check("wrap_first", 32'(req_ready), 32'h8);
        tick();
        check("wrap_busy", 32'(req_ready), 32'h0);
        tick();
        tick();
        check("wrap_rsp_id3", 32'(rsp_id), 32'h3);
        check("wrap_rsp_data3", rsp_data, vecs[3].exp);
        check("wrap_second", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        check("wrap_add_in0", add_in0, vecs[1].a);
        tick();
        tick();
        check("wrap_rsp_valid1", 32'(rsp_valid), 32'h1);
        check("wrap_rsp_id1", 32'(rsp_id), 32'h1);
        tick();

        // Continuous contention from reset.
        do_reset();
        stream(5);
        tick();

        // Reset asserted in the middle of a BUSY period.
        do_reset();
        req_valid = 4'b0010;
        #1;
        check("midrst_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        #2;
        rst = 1'b1;
        #1;
        check_zero_outputs("midrst");
        tick();
        tick();
        check("midrst_no_rsp", 32'(rsp_valid), 32'h0);
        #3;
        rst = 1'b0;
        tick();
        check("midrst_no_rsp2", 32'(rsp_valid), 32'h0);
        tick();
        check("midrst_no_rsp3", 32'(rsp_valid), 32'h0);
        req_valid = 4'b0111;
        #1;
        check("midrst_next_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        tick();
        tick();
        check("midrst_rsp_id", 32'(rsp_id), 32'h0);
        check("midrst_rsp_data", rsp_data, vecs[0].exp);
        tick();

`ifdef F_ADDER_ARB_STATS_EN
        do_reset();
        check("stat_ops_reset", 32'(stat_ops), 32'd0);
        check("stat_busy_reset", 32'(stat_busy), 32'd0);
        stream(5);
        tick();
        check("stat_ops_count", 32'(stat_ops), 32'd5);
        check("stat_busy_count", 32'(stat_busy), 32'd10);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        check("stat_ops_clr", 32'(stat_ops), 32'd0);
        check("stat_busy_clr", 32'(stat_busy), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
